ahb_lite_mem_bist: RTL and testbench
====================================

// Module: ahb_lite_mem_bist
// PURPOSE
//  AHB-Lite master that drives the HADDR..HWRITE inputs of ahb_lite_sdram (via HREADY/HRDATA mux).
//  On start: write pass fills WORDS words from BASE_ADDR with addr^PATTERN, then read pass compares.
//  Reports pass/fail, saturating error count, first failing address. Used for board bring-up and regression.
// PARAMETERS
//  ADDR_W     32            HADDR width
//  DATA_W     32            HWDATA/HRDATA width (word transfers only)
//  BASE_ADDR  32'h0000_0000 first byte address, word aligned
//  WORDS      1024          words tested, >=1; BASE_ADDR+4*WORDS <= 2**ADDR_W
//  PATTERN    32'hA5A5_5A5A data = HADDR ^ PATTERN
// PORTS
//  HCLK       in   1       clock
//  HRESETn    in   1       async active-low reset
//  start      in   1       1-cycle pulse, starts test when !busy
//  busy       out  1       test in progress
//  done       out  1       held high from end of test until next accepted start
//  pass       out  1       valid when done: err_cnt==0 && !bus_err
//  bus_err    out  1       HRESP error aborted test
//  err_cnt    out  16      read mismatches, saturates at 16'hFFFF
//  fail_addr  out  ADDR_W  address of first mismatch/error
//  HADDR      out  ADDR_W  HBURST out 3  HMASTLOCK out 1  HPROT out 4
//  HSIZE      out  3       HTRANS out 2  HWRITE out 1  HWDATA out DATA_W
//  HRDATA     in   DATA_W  HREADY in 1  HRESP in 1
// BEHAVIOUR
//  Reset: all outputs 0; HTRANS=IDLE; state IDLE. Constants: HBURST=SINGLE, HSIZE=3'b010,
//   HPROT=4'b0011, HMASTLOCK=0.
//  States: IDLE -start-> WR -last write addr accepted-> RD -last read addr accepted-> DRAIN
//   -last data phase done-> DONE -start-> WR. start ignored in WR/RD/DRAIN.
//  Accepting start: clears done, pass, bus_err, err_cnt, fail_addr; busy=1 next cycle.
//  Address phase: WR/RD drive HTRANS=NONSEQ, HADDR=BASE_ADDR+4*idx, HWRITE=(WR).
//   Address accepted on HCLK rise with HREADY=1; idx increments; HADDR/HTRANS/HWRITE held while HREADY=0.
//   idx resets to 0 at WR->RD; back-to-back: first read address overlaps last write data phase.
//  Data-phase register (dp_valid, dp_write, dp_addr) loaded on address acceptance.
//   Write data phase: HWDATA = dp_addr ^ PATTERN, held until HREADY=1.
//   Read data phase ends on HREADY=1: HRDATA != dp_addr^PATTERN -> err_cnt+1 (sat),
//   fail_addr captured only if first error.
//  HTRANS=IDLE in DRAIN/DONE/IDLE; HWDATA don't-care when no write data phase.
//  HRESP=1 & HREADY=0 (1st error cycle): next cycle HTRANS=IDLE (cancel pending),
//   bus_err=1, fail_addr=dp_addr if none captured; after 2nd cycle -> DONE, pass=0.
//  done, pass update in same cycle as DRAIN->DONE; busy falls same cycle.
//  WORDS=1: WR and RD each one cycle of address phase when HREADY=1.
//  HRESETn low any time: immediate return to reset values; no partial result retained.
// STRUCTURE
//  Shared package ahb_lite_pkg: HTRANS_IDLE/NONSEQ, HBURST_SINGLE, HSIZE_WORD consts,
//   bist_state_t enum {IDLE,WR,RD,DRAIN,DONE}, function bist_pattern(addr,pattern).
//  Single module; no sub-modules (address counter + data-phase register inline).
// TESTING
//  1 Zero-wait slave, WORDS=16, BASE=0 -> 32 NONSEQ xfers, done within 35 cycles, pass=1, err_cnt=0.
//  2 Through ahb_lite_sdram + sdr model, WORDS=256 -> pass=1; HADDR/HTRANS stable whenever HREADY=0.
//  3 Slave flips bit0 of read at 0x28 -> err_cnt=1, fail_addr=0x28, pass=0.
//  4 HRESP error on write 0x10 -> HTRANS=IDLE in 2nd error cycle, bus_err=1, done=1, pass=0, fail_addr=0x10.
//  5 HRESETn low mid read pass -> outputs 0, HTRANS=IDLE at once; new start -> full run, pass=1.
//  6 start during busy ignored; start in DONE after failed run -> err_cnt/bus_err cleared, rerun passes.

Source files
------------

// File: rtl/ahb_lite_pkg.sv
// ahb_lite_pkg: shared AHB-Lite encodings and the memory-BIST state type.
//
// Contents:
//   HTRANS_IDLE / HTRANS_NONSEQ   transfer type encodings
//   HBURST_SINGLE, HSIZE_WORD     fixed burst / size encodings used by the BIST master
//   HPROT_DATA_PRIV               data access, privileged
//   bist_state_t                  BIST sequencer states
//   bist_pattern()                data word written/expected at a given address
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE     = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ   = 2'b10;
  localparam logic [2:0] HBURST_SINGLE   = 3'b000;
  localparam logic [2:0] HSIZE_WORD      = 3'b010;
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

  // Wide enough for any sensible ADDR_W/DATA_W; callers cast down to their width.
  localparam int unsigned BIST_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    DRAIN,
    DONE
  } bist_state_t;

  function automatic logic [BIST_W-1:0] bist_pattern(input logic [BIST_W-1:0] addr,
                                                     input logic [BIST_W-1:0] pattern);
    return addr ^ pattern;
  endfunction

endpackage

// File: rtl/ahb_lite_mem_bist.sv
// ahb_lite_mem_bist: AHB-Lite master that writes WORDS words starting at BASE_ADDR with
// addr ^ PATTERN, reads them back and compares. Reports pass/fail, a saturating mismatch
// count and the first failing address. An HRESP error aborts the run.
//
// Ports:
//   HCLK, HRESETn          clock, asynchronous active-low reset
//   start                  one-cycle pulse, accepted only when not busy
//   busy                   write/read/drain in progress
//   done                   held from end of run until the next accepted start
//   pass                   valid with done: no mismatches and no bus error
//   bus_err                run aborted by an HRESP error
//   err_cnt                read mismatches, saturating at 16'hFFFF
//   fail_addr              address of the first mismatch or bus error
//   HADDR..HWDATA          AHB-Lite master outputs (single word transfers only)
//   HRDATA, HREADY, HRESP  AHB-Lite slave responses
module ahb_lite_mem_bist
  import ahb_lite_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       WORDS     = 1024,
  parameter logic [DATA_W-1:0] PATTERN   = 32'hA5A5_5A5A
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              bus_err,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [ADDR_W-1:0] HADDR,
  output logic [2:0]        HBURST,
  output logic              HMASTLOCK,
  output logic [3:0]        HPROT,
  output logic [2:0]        HSIZE,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  localparam int unsigned     IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  bist_state_t       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              dp_valid_q, dp_valid_d;
  logic              dp_write_q, dp_write_d;
  logic [ADDR_W-1:0] dp_addr_q, dp_addr_d;
  logic              abort_q, abort_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              bus_err_q, bus_err_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic              fail_cap_q, fail_cap_d;

  logic              in_busy;
  logic              addr_phase;
  logic              addr_acc;
  logic              dp_done;
  logic              rd_mismatch;
  logic              err_first;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] exp_data;

  assign in_busy    = (state_q == WR) || (state_q == RD) || (state_q == DRAIN);
  // Once an error response is seen the pending address phase is withdrawn.
  assign addr_phase = ((state_q == WR) || (state_q == RD)) && !abort_q;
  assign addr_acc   = addr_phase && HREADY;
  assign cur_addr   = BASE_ADDR + ADDR_W'({idx_q, 2'b00});
  assign exp_data   = DATA_W'(bist_pattern(BIST_W'(dp_addr_q), BIST_W'(PATTERN)));

  // Normal data-phase completion; the second error cycle is not a completion.
  assign dp_done     = dp_valid_q && HREADY && !abort_q;
  assign rd_mismatch = dp_done && !dp_write_q && (HRDATA != exp_data);
  // First cycle of the two-cycle error response.
  assign err_first   = in_busy && dp_valid_q && HRESP && !HREADY && !abort_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dp_valid_d  = dp_valid_q;
    dp_write_d  = dp_write_q;
    dp_addr_d   = dp_addr_q;
    abort_d     = abort_q;
    done_d      = done_q;
    pass_d      = pass_q;
    bus_err_d   = bus_err_q;
    err_cnt_d   = err_cnt_q;
    fail_addr_d = fail_addr_q;
    fail_cap_d  = fail_cap_q;

    // The data-phase register only advances with the bus pipeline (HREADY high).
    if (HREADY) begin
      dp_valid_d = addr_acc;
      if (addr_acc) begin
        dp_write_d = (state_q == WR);
        dp_addr_d  = cur_addr;
      end
    end

    if (rd_mismatch) begin
      if (err_cnt_q != 16'hFFFF) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end
      if (!fail_cap_q) begin
        fail_cap_d  = 1'b1;
        fail_addr_d = dp_addr_q;
      end
    end

    if (err_first) begin
      abort_d   = 1'b1;
      bus_err_d = 1'b1;
      if (!fail_cap_q) begin
        fail_cap_d  = 1'b1;
        fail_addr_d = dp_addr_q;
      end
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = WR;
          idx_d       = '0;
          dp_valid_d  = 1'b0;
          abort_d     = 1'b0;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          bus_err_d   = 1'b0;
          err_cnt_d   = '0;
          fail_addr_d = '0;
          fail_cap_d  = 1'b0;
        end
      end
      WR: begin
        if (addr_acc) begin
          if (idx_q == LAST_IDX) begin
            // First read address overlaps the last write data phase.
            state_d = RD;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      RD: begin
        if (addr_acc) begin
          if (idx_q == LAST_IDX) begin
            state_d = DRAIN;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DRAIN: begin
        if (dp_done) begin
          state_d = DONE;
          done_d  = 1'b1;
          // Uses the updated count so the final read is included.
          pass_d  = (err_cnt_d == 16'd0) && !bus_err_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // Second error cycle: the slave has finished the response, stop here.
    if (abort_q && HREADY) begin
      state_d    = DONE;
      done_d     = 1'b1;
      pass_d     = 1'b0;
      abort_d    = 1'b0;
      dp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_addr_q   <= '0;
      abort_q     <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      bus_err_q   <= 1'b0;
      err_cnt_q   <= '0;
      fail_addr_q <= '0;
      fail_cap_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      dp_addr_q   <= dp_addr_d;
      abort_q     <= abort_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      bus_err_q   <= bus_err_d;
      err_cnt_q   <= err_cnt_d;
      fail_addr_q <= fail_addr_d;
      fail_cap_q  <= fail_cap_d;
    end
  end

  assign busy      = in_busy;
  assign done      = done_q;
  assign pass      = pass_q;
  assign bus_err   = bus_err_q;
  assign err_cnt   = err_cnt_q;
  assign fail_addr = fail_addr_q;

  assign HTRANS    = addr_phase ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR     = addr_phase ? cur_addr : '0;
  assign HWRITE    = addr_phase && (state_q == WR);
  assign HWDATA    = (dp_valid_q && dp_write_q) ? exp_data : '0;
  assign HBURST    = HBURST_SINGLE;
  assign HSIZE     = HSIZE_WORD;
  assign HPROT     = HPROT_DATA_PRIV;
  assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb_lite_mem_bist.sv
// Bench for ahb_lite_mem_bist: a memory slave model with programmable wait states, read
// bit-flips and an error address; a table of runs with hand-computed results, plus a
// reset-during-read sequence.
module tb_ahb_lite_mem_bist;

  localparam int unsigned WORDS = 16;
  localparam logic [31:0] PAT   = 32'hA5A5_5A5A;
  localparam logic [31:0] NONE  = 32'hFFFF_FFFF;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, pass, bus_err;
  logic [15:0] err_cnt;
  logic [31:0] fail_addr, HADDR, HWDATA, HRDATA;
  logic [2:0]  HBURST, HSIZE;
  logic        HMASTLOCK, HWRITE, HREADY, HRESP;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;

  always #5 HCLK = ~HCLK;

  ahb_lite_mem_bist #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .BASE_ADDR(32'h0),
    .WORDS    (WORDS),
    .PATTERN  (PAT)
  ) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .bus_err  (bus_err),
    .err_cnt  (err_cnt),
    .fail_addr(fail_addr),
    .HADDR    (HADDR),
    .HBURST   (HBURST),
    .HMASTLOCK(HMASTLOCK),
    .HPROT    (HPROT),
    .HSIZE    (HSIZE),
    .HTRANS   (HTRANS),
    .HWRITE   (HWRITE),
    .HWDATA   (HWDATA),
    .HRDATA   (HRDATA),
    .HREADY   (HREADY),
    .HRESP    (HRESP)
  );

  // ---------------- slave model ----------------
  int          cfg_waits = 0;
  logic [15:0] cfg_flip = '0;
  logic [31:0] cfg_err_addr = NONE;

  logic [31:0] mem [16];
  logic        s_dp_valid, s_dp_write;
  logic [31:0] s_dp_addr;
  int          s_cnt;
  int          xfers = 0, viol = 0, wbad = 0;

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    logic [3:0] w;
    w = a[5:2];
    return mem[w] ^ {31'b0, cfg_flip[w]};
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HREADY     <= 1'b1;
      HRESP      <= 1'b0;
      HRDATA     <= '0;
      s_dp_valid <= 1'b0;
      s_dp_write <= 1'b0;
      s_dp_addr  <= '0;
      s_cnt      <= 0;
    end else if (HREADY) begin
      if (HRESP) HRESP <= 1'b0;
      if (s_dp_valid && s_dp_write && !HRESP) begin
        mem[s_dp_addr[5:2]] <= HWDATA;
        if (HWDATA !== (s_dp_addr ^ PAT)) wbad <= wbad + 1;
      end
      if (HTRANS == 2'b10) begin
        s_dp_valid <= 1'b1;
        s_dp_write <= HWRITE;
        s_dp_addr  <= HADDR;
        if (HADDR == cfg_err_addr) begin
          HREADY <= 1'b0;
          HRESP  <= 1'b1;
        end else if (cfg_waits != 0) begin
          HREADY <= 1'b0;
          s_cnt  <= cfg_waits - 1;
        end else begin
          HREADY <= 1'b1;
          HRDATA <= rd_val(HADDR);
        end
      end else begin
        s_dp_valid <= 1'b0;
        HREADY     <= 1'b1;
      end
    end else begin
      if (HRESP) begin
        HREADY <= 1'b1;
      end else if (s_cnt == 0) begin
        HREADY <= 1'b1;
        HRDATA <= rd_val(s_dp_addr);
      end else begin
        s_cnt <= s_cnt - 1;
      end
    end
  end

  // Protocol monitor: accepted transfers, address held during wait states,
  // and no transfer offered in the second error cycle.
  logic        p_v = 1'b0, p_ready = 1'b1, p_resp = 1'b0, p_write = 1'b0;
  logic [1:0]  p_trans = 2'b00;
  logic [31:0] p_addr = '0;

  always @(posedge HCLK) begin
    if (!HRESETn) begin
      p_v <= 1'b0;
    end else begin
      if (HTRANS == 2'b10 && HREADY) xfers <= xfers + 1;
      if (p_v && !p_ready && !p_resp && p_trans == 2'b10 &&
          (HTRANS != p_trans || HADDR != p_addr || HWRITE != p_write)) viol <= viol + 1;
      if (HRESP && HREADY && HTRANS != 2'b00) viol <= viol + 1;
      p_v     <= 1'b1;
      p_ready <= HREADY;
      p_resp  <= HRESP;
      p_trans <= HTRANS;
      p_addr  <= HADDR;
      p_write <= HWRITE;
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    int          waits;
    logic [15:0] flip;
    logic [31:0] err_addr;
    int          extra_start;
    logic        exp_pass;
    logic [15:0] exp_cnt;
    logic [31:0] exp_fail;
    logic        exp_berr;
    int          exp_xfers;
    int          max_cyc;
  } vec_t;

  vec_t vecs[11];

  task automatic run_vec(input vec_t v);
    int cycles, x0, v0, w0;
    cfg_waits    = v.waits;
    cfg_flip     = v.flip;
    cfg_err_addr = v.err_addr;
    x0 = xfers;
    v0 = viol;
    w0 = wbad;
    @(negedge HCLK);
    start = 1'b1;
    @(negedge HCLK);
    start  = 1'b0;
    cycles = 1;
    chk({v.name, ".busy_after_start"}, {31'b0, busy}, 32'd1);
    chk({v.name, ".done_cleared"}, {31'b0, done}, 32'd0);
    chk({v.name, ".cnt_cleared"}, {16'b0, err_cnt}, 32'd0);
    chk({v.name, ".berr_cleared"}, {31'b0, bus_err}, 32'd0);
    while (!done && cycles < 2000) begin
      @(negedge HCLK);
      cycles++;
      start = (cycles == v.extra_start);
    end
    start = 1'b0;
    checks++;
    if (cycles > v.max_cyc) begin
      errors++;
      $display("FAIL %s.latency actual=%0d cycles required<=%0d", v.name, cycles, v.max_cyc);
    end
    chk({v.name, ".done"}, {31'b0, done}, 32'd1);
    chk({v.name, ".busy_end"}, {31'b0, busy}, 32'd0);
    chk({v.name, ".pass"}, {31'b0, pass}, {31'b0, v.exp_pass});
    chk({v.name, ".err_cnt"}, {16'b0, err_cnt}, {16'b0, v.exp_cnt});
    chk({v.name, ".fail_addr"}, fail_addr, v.exp_fail);
    chk({v.name, ".bus_err"}, {31'b0, bus_err}, {31'b0, v.exp_berr});
    chk({v.name, ".htrans_idle"}, {30'b0, HTRANS}, 32'd0);
    chk({v.name, ".xfers"}, 32'(xfers - x0), 32'(v.exp_xfers));
    chk({v.name, ".protocol"}, 32'(viol - v0), 32'd0);
    chk({v.name, ".wdata"}, 32'(wbad - w0), 32'd0);
  endtask

  initial begin
    //          name             wt flip      err_addr    xs  pass cnt  fail      berr xf  max
    vecs[0]  = '{"clean0",        0, 16'h0000, NONE,        0, 1'b1, 16'd0, 32'h00, 1'b0, 32, 35};
    vecs[1]  = '{"flip28",        0, 16'h0400, NONE,        0, 1'b0, 16'd1, 32'h28, 1'b0, 32, 35};
    vecs[2]  = '{"err_wr10",      0, 16'h0000, 32'h10,      0, 1'b0, 16'd0, 32'h10, 1'b1, 5,  35};
    vecs[3]  = '{"clean_after",   0, 16'h0000, NONE,        0, 1'b1, 16'd0, 32'h00, 1'b0, 32, 35};
    vecs[4]  = '{"clean_w2",      2, 16'h0000, NONE,        0, 1'b1, 16'd0, 32'h00, 1'b0, 32, 110};
    vecs[5]  = '{"flip2_w1",      1, 16'h0408, NONE,        0, 1'b0, 16'd2, 32'h0C, 1'b0, 32, 80};
    vecs[6]  = '{"flip_last",     0, 16'h8000, NONE,        0, 1'b0, 16'd1, 32'h3C, 1'b0, 32, 35};
    vecs[7]  = '{"err_wr10_w2",   2, 16'h0000, 32'h10,      0, 1'b0, 16'd0, 32'h10, 1'b1, 5,  40};
    vecs[8]  = '{"start_in_wr",   0, 16'h0000, NONE,        8, 1'b1, 16'd0, 32'h00, 1'b0, 32, 35};
    vecs[9]  = '{"start_in_rd",   1, 16'h0000, NONE,       40, 1'b1, 16'd0, 32'h00, 1'b0, 32, 80};
    vecs[10] = '{"err_last_wr",   0, 16'h0000, 32'h3C,      0, 1'b0, 16'd0, 32'h3C, 1'b1, 16, 35};

    // Reset values and constant bus attributes.
    #12;
    chk("rst.busy", {31'b0, busy}, 32'd0);
    chk("rst.done", {31'b0, done}, 32'd0);
    chk("rst.pass", {31'b0, pass}, 32'd0);
    chk("rst.bus_err", {31'b0, bus_err}, 32'd0);
    chk("rst.err_cnt", {16'b0, err_cnt}, 32'd0);
    chk("rst.fail_addr", fail_addr, 32'd0);
    chk("rst.htrans", {30'b0, HTRANS}, 32'd0);
    chk("rst.hwrite", {31'b0, HWRITE}, 32'd0);
    chk("rst.haddr", HADDR, 32'd0);
    chk("rst.hburst", {29'b0, HBURST}, 32'd0);
    chk("rst.hsize", {29'b0, HSIZE}, 32'd2);
    chk("rst.hprot", {28'b0, HPROT}, 32'd3);
    chk("rst.hmastlock", {31'b0, HMASTLOCK}, 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Reset in the middle of the read pass, after one mismatch was counted.
    begin
      int n;
      cfg_waits    = 0;
      cfg_flip     = 16'h0002;
      cfg_err_addr = NONE;
      @(negedge HCLK);
      start = 1'b1;
      @(negedge HCLK);
      start = 1'b0;
      n = 0;
      while (!(HTRANS == 2'b10 && !HWRITE) && n < 100) begin
        @(negedge HCLK);
        n++;
      end
      chk("midrst.reached_read", {31'b0, (n < 100)}, 32'd1);
      repeat (3) @(negedge HCLK);
      chk("midrst.cnt_before", {16'b0, err_cnt}, 32'd1);
      #2;
      HRESETn = 1'b0;
      #1;
      chk("midrst.busy", {31'b0, busy}, 32'd0);
      chk("midrst.htrans", {30'b0, HTRANS}, 32'd0);
      chk("midrst.err_cnt", {16'b0, err_cnt}, 32'd0);
      chk("midrst.fail_addr", fail_addr, 32'd0);
      chk("midrst.done", {31'b0, done}, 32'd0);
      @(negedge HCLK);
      HRESETn = 1'b1;
      run_vec(vecs[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
